mmio_tx_poller: RTL

MMIO_TX_POLLER -- requirements
Module: mmio_tx_poller

---
 rtl/mmio_tx_poller.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mmio_tx_poller.sv
// mmio_tx_poller: byte FIFO drained into a memory-mapped UART by polling.
// The FSM polls the status register until tx-ready is set, then writes one byte.
// Optional feature: define MMIO_TX_STATS_EN to add the bytes_sent counter output.
module mmio_tx_poller #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] STATUS_ADDR = 32'h8000_0000,
  parameter logic [31:0] TX_ADDR     = 32'h8000_0008,
  parameter int          POLL_GAP    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  push_data,
  input  logic        push_valid,
  output logic        push_ready,
  output logic [31:0] mmio_addr,
  output logic        mmio_rd,
  output logic        mmio_wr,
  output logic [31:0] mmio_wdata,
  input  logic [31:0] mmio_rdata,
  output logic        busy
`ifdef MMIO_TX_STATS_EN
  ,
  output logic [31:0] bytes_sent
`endif
);

  localparam int              AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]     DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
  localparam logic [7:0]      GAP_LOAD  = 8'(POLL_GAP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POLL = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     count_next;
  logic [7:0]      gap_cnt;
  logic [7:0]      head;
  logic            push_fire;
  logic            pop;
  logic            tx_ready;
  logic            unused_rdata;

  // Only bit 0 of the status word carries meaning; the rest is deliberately dropped.
  assign tx_ready     = mmio_rdata[0];
  assign unused_rdata = ^mmio_rdata[31:1];

  // Full is judged on the registered count, so a pop never frees a slot in the same cycle.
  assign push_ready = (count < DEPTH_CNT);
  assign push_fire  = push_valid && push_ready;
  assign pop        = (state == SEND);
  assign head       = mem[rd_ptr];
  assign busy       = (count != '0) || (state != IDLE);

  // Occupancy after this edge, used by SEND to decide between POLL and IDLE.
  always_comb begin
    count_next = count;
    if (push_fire && !pop) begin
      count_next = count + CNT_ONE;
    end else if (!push_fire && pop) begin
      count_next = count - CNT_ONE;
    end
  end

  // Byte storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_next;
    end
  end

  // Poll/send controller with registered MMIO strobes; addr and data idle at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      mmio_rd    <= 1'b0;
      mmio_wr    <= 1'b0;
      mmio_addr  <= '0;
      mmio_wdata <= '0;
    end else begin
      mmio_rd    <= 1'b0;
      mmio_wr    <= 1'b0;
      mmio_addr  <= '0;
      mmio_wdata <= '0;
      case (state)
        IDLE: begin
          if (count != '0) begin
            state     <= POLL;
            mmio_rd   <= 1'b1;
            mmio_addr <= STATUS_ADDR;
          end
        end
        POLL: begin
          if (tx_ready) begin
            state      <= SEND;
            mmio_wr    <= 1'b1;
            mmio_addr  <= TX_ADDR;
            mmio_wdata <= {24'b0, head};
          end else begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state     <= POLL;
            mmio_rd   <= 1'b1;
            mmio_addr <= STATUS_ADDR;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        SEND: begin
          if (count_next != '0) begin
            state     <= POLL;
            mmio_rd   <= 1'b1;
            mmio_addr <= STATUS_ADDR;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MMIO_TX_STATS_EN
  // Running count of bytes written to the UART, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bytes_sent <= '0;
    end else if (pop) begin
      bytes_sent <= bytes_sent + 32'd1;
    end
  end
`endif

endmodule
